// File: rtl/systolic_pkg.sv
// Shared defaults, controller state encoding and flat-bus offset helpers for the
// 4x4 systolic array and its tile controller.
package systolic_pkg;

  localparam int unsigned DEF_AW   = 8;
  localparam int unsigned DEF_BW   = 8;
  localparam int unsigned DEF_ACCW = 32;
  localparam int unsigned DEF_ROWS = 4;
  localparam int unsigned DEF_COLS = 4;
  localparam int unsigned DEF_K    = 4;
  localparam int unsigned DEF_TMO  = 64;

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  // Bit offset of element (row, col) of an ncols-wide matrix packed row-major at w bits each.
  function automatic int unsigned flat_off(input int unsigned row, input int unsigned col,
                                           input int unsigned ncols, input int unsigned w);
    return ((row * ncols) + col) * w;
  endfunction

  // Same offset addressed by the row-major linear element index.
  function automatic int unsigned lin_off(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/tile_result_drain.sv
// Captures the array's flat result bus and replays it as a row-major valid/ready word stream.
module tile_result_drain
  import systolic_pkg::*;
#(
  parameter int unsigned ACCW = DEF_ACCW,
  parameter int unsigned C_N  = DEF_ROWS * DEF_COLS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_capture,
  input  logic [C_N*ACCW-1:0] i_arr_c,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [ACCW-1:0]   o_data,
  output logic              o_last,
  output logic              o_last_hs_c
);

  localparam int unsigned IDX_W = (C_N > 1) ? $clog2(C_N) : 1;

  logic [ACCW-1:0]  w_c_in  [C_N];
  logic [ACCW-1:0]  r_c_mem [C_N];
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_inc;
  logic             r_valid;
  logic [ACCW-1:0]  r_data;
  logic             r_last;
  logic             w_hs;

  for (genvar g = 0; g < C_N; g++) begin : g_unpack_c
    assign w_c_in[g] = i_arr_c[lin_off(g, ACCW) +: ACCW];
  end

  assign w_hs      = r_valid && i_ready;
  assign w_idx_inc = r_idx + IDX_W'(1);

  // Word 0 is presented in the capture cycle so the stream starts right after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_mem <= '{default: '0};
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_capture) begin
      r_c_mem <= w_c_in;
      r_idx   <= '0;
      r_valid <= 1'b1;
      r_data  <= w_c_in[0];
      r_last  <= (C_N == 1);
    end else if (w_hs) begin
      if (r_last) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_data  <= '0;
      end else begin
        r_idx  <= w_idx_inc;
        r_data <= r_c_mem[w_idx_inc];
        r_last <= (w_idx_inc == IDX_W'(C_N - 1));
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_last      = r_last;
  assign o_last_hs_c = w_hs && r_last;

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Tile initiator for the systolic array: loads A/B operands from a stream, starts the
// array, watches for done with a watchdog and drains the results as a stream.
module systolic_tile_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned AW   = DEF_AW,
  parameter int unsigned BW   = DEF_BW,
  parameter int unsigned ACCW = DEF_ACCW,
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned K    = DEF_K,
  parameter int unsigned TMO  = DEF_TMO
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [AW-1:0]             in_data,
  output logic                      arr_start,
  output logic [ROWS*K*AW-1:0]      arr_A,
  output logic [K*COLS*BW-1:0]      arr_B,
  input  logic                      arr_done,
  input  logic [ROWS*COLS*ACCW-1:0] arr_C,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACCW-1:0]           out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int unsigned A_N   = ROWS * K;
  localparam int unsigned B_N   = K * COLS;
  localparam int unsigned C_N   = ROWS * COLS;
  localparam int unsigned LD_N  = (A_N > B_N) ? A_N : B_N;
  localparam int unsigned IDX_W = (LD_N > 1) ? $clog2(LD_N) : 1;
  localparam int unsigned WD_W  = (TMO > 2) ? $clog2(TMO) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [WD_W-1:0]  r_wd_cnt;
  logic [WD_W-1:0]  w_wd_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             r_in_ready;
  logic             w_in_ready_nxt;
  logic             r_arr_start;
  logic             w_arr_start_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             w_capture;
  logic             w_in_hs;
  logic             w_a_we;
  logic             w_b_we;
  logic             w_last_hs_c;

  logic [AW-1:0]    r_a_mem [A_N];
  logic [BW-1:0]    r_b_mem [B_N];

  assign w_in_hs = in_valid && r_in_ready;
  assign w_a_we  = w_in_hs && (r_state == S_LOAD_A);
  assign w_b_we  = w_in_hs && (r_state == S_LOAD_B);

  // Next-state, counters and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wd_nxt    = r_wd_cnt;
    w_err_nxt   = r_err;
    w_capture   = 1'b0;

    // Any accepted operand word acknowledges a previous timeout.
    if (w_in_hs) w_err_nxt = 1'b0;

    unique case (r_state)
      S_LOAD_A: begin
        if (w_in_hs) begin
          if (r_idx == IDX_W'(A_N - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_LOAD_B;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_LOAD_B: begin
        if (w_in_hs) begin
          if (r_idx == IDX_W'(B_N - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_START;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_START: begin
        w_wd_nxt    = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Done has priority over a coincident watchdog expiry.
        if (arr_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DRAIN;
        end else if (r_wd_cnt == WD_W'(TMO - 2)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_LOAD_A;
        end else begin
          w_wd_nxt = r_wd_cnt + WD_W'(1);
        end
      end
      S_DRAIN: begin
        if (w_last_hs_c) w_state_nxt = S_LOAD_A;
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = S_LOAD_A;
      end
    endcase

    w_in_ready_nxt  = (w_state_nxt == S_LOAD_A) || (w_state_nxt == S_LOAD_B);
    w_arr_start_nxt = (w_state_nxt == S_START);
    w_busy_nxt      = (w_state_nxt == S_START) || (w_state_nxt == S_WAIT) ||
                      (w_state_nxt == S_DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD_A;
      r_idx       <= '0;
      r_wd_cnt    <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_arr_start <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_wd_cnt    <= w_wd_nxt;
      r_err       <= w_err_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_arr_start <= w_arr_start_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Operand tile storage; written only on operand handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_mem <= '{default: '0};
      r_b_mem <= '{default: '0};
    end else begin
      if (w_a_we) r_a_mem[r_idx] <= in_data;
      if (w_b_we) r_b_mem[r_idx] <= in_data[BW-1:0];
    end
  end

  for (genvar g = 0; g < A_N; g++) begin : g_pack_a
    assign arr_A[lin_off(g, AW) +: AW] = r_a_mem[g];
  end

  for (genvar g = 0; g < B_N; g++) begin : g_pack_b
    assign arr_B[lin_off(g, BW) +: BW] = r_b_mem[g];
  end

  tile_result_drain #(
    .ACCW (ACCW),
    .C_N  (C_N)
  ) u_drain (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_capture   (w_capture),
    .i_arr_c     (arr_C),
    .i_ready     (out_ready),
    .o_valid     (out_valid),
    .o_data      (out_data),
    .o_last      (out_last),
    .o_last_hs_c (w_last_hs_c)
  );

  assign in_ready    = r_in_ready;
  assign arr_start   = r_arr_start;
  assign busy        = r_busy;
  assign err_timeout = r_err;

endmodule
